// File: rtl/bsg_serial_in_parallel_out_frame_pkg.sv
// Shared helpers for the serial-in / parallel-out frame assembler.
//   safe_clog2 : ceil(log2(x)) but never less than 1, so a counter for a
//                single-entry range still gets a legal one-bit width.
package bsg_serial_in_parallel_out_frame_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_serial_in_parallel_out_frame_dff.sv
// Register with load enable and asynchronous active-high reset to zero.
// Holds the assembled output frame and its valid bit.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset, clears the register
//   en_i    : load data_i on the next rising edge
//   data_i  : next value
//   data_o  : registered value
module bsg_serial_in_parallel_out_frame_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_serial_in_parallel_out_frame.sv
// Reassembles a stream of width_p-bit words into els_p-word frames.
// Input handshake is valid-then-yumi (this block consumes); the output frame
// is registered and handed downstream with a valid-then-yumi handshake.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset; discards any partial frame
//   v_i     : serial word valid
//   data_i  : serial word
//   yumi_o  : serial word consumed this cycle (combinational on v_i, yumi_i)
//   valid_o : assembled frame valid
//   data_o  : assembled frame; first word in slot 0 unless hi_to_lo_p
//   yumi_i  : downstream consumes the frame (only while valid_o)
module bsg_serial_in_parallel_out_frame
  import bsg_serial_in_parallel_out_frame_pkg::*;
#(
  parameter int width_p    = -1,
  parameter int els_p      = -1,
  parameter int hi_to_lo_p = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic [width_p-1:0]              data_i,
  output logic                            yumi_o,
  output logic                            valid_o,
  output logic [els_p-1:0][width_p-1:0]   data_o,
  input  logic                            yumi_i
);

  logic [els_p-1:0][width_p-1:0] frame_d;    // frame in arrival order
  logic [els_p-1:0][width_p-1:0] frame_ord;  // frame after optional reversal
  logic                          load;       // last word of a frame accepted
  logic                          out_v_d;

  if (els_p == 1) begin : g_single
    // One-entry pipe: every accepted word is a complete frame.
    assign yumi_o  = v_i & ~reset_i & (~valid_o | yumi_i);
    assign load    = yumi_o;
    assign frame_d = data_i;
  end else begin : g_multi
    localparam int CtrW = safe_clog2(els_p);
    localparam logic [CtrW-1:0] CtrMax = CtrW'(els_p - 1);

    logic [CtrW-1:0]               ctr_q, ctr_d;
    logic [els_p-2:0][width_p-1:0] asm_q;
    logic                          is_last;

    assign is_last = (ctr_q == CtrMax);
    // Only the last word can stall: it needs the output register free.
    assign yumi_o  = v_i & ~reset_i & (~is_last | ~valid_o | yumi_i);
    assign load    = yumi_o & is_last;

    always_comb begin
      ctr_d = ctr_q;
      if (yumi_o) begin
        ctr_d = is_last ? '0 : ctr_q + CtrW'(1);
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        ctr_q <= '0;
      end else begin
        ctr_q <= ctr_d;
      end
    end

    // Assembly slots carry no reset; the counter alone marks them stale.
    always_ff @(posedge clk_i) begin
      for (int i = 0; i < els_p - 1; i++) begin
        if (yumi_o && (ctr_q == CtrW'(i))) begin
          asm_q[i] <= data_i;
        end
      end
    end

    assign frame_d = {data_i, asm_q};
  end

  if (hi_to_lo_p != 0) begin : g_rev
    for (genvar i = 0; i < els_p; i++) begin : g_word
      assign frame_ord[i] = frame_d[els_p-1-i];
    end
  end else begin : g_fwd
    assign frame_ord = frame_d;
  end

  // A new frame landing in the same cycle as a consume keeps valid high.
  assign out_v_d = load | (valid_o & ~yumi_i);

  bsg_serial_in_parallel_out_frame_dff #(
    .width_p (1)
  ) u_valid (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (1'b1),
    .data_i  (out_v_d),
    .data_o  (valid_o)
  );

  bsg_serial_in_parallel_out_frame_dff #(
    .width_p (els_p * width_p)
  ) u_frame (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (load),
    .data_i  (frame_ord),
    .data_o  (data_o)
  );

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_frame.sv
module tb_bsg_serial_in_parallel_out_frame;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: els_p=4 low-to-high, b: els_p=4 high-to-low, c: els_p=1
  logic            va, ya, yumi_oa, valid_oa;
  logic [7:0]      da;
  logic [3:0][7:0] data_oa;
  logic            vb, yb, yumi_ob, valid_ob;
  logic [7:0]      db;
  logic [3:0][7:0] data_ob;
  logic            vc, yc, yumi_oc, valid_oc;
  logic [7:0]      dc;
  logic [0:0][7:0] data_oc;

  int checks = 0;
  int errors = 0;
  logic a_hold = 1'b0;

  bsg_serial_in_parallel_out_frame #(.width_p(8), .els_p(4), .hi_to_lo_p(0)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(va), .data_i(da), .yumi_o(yumi_oa),
    .valid_o(valid_oa), .data_o(data_oa), .yumi_i(ya)
  );

  bsg_serial_in_parallel_out_frame #(.width_p(8), .els_p(4), .hi_to_lo_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(vb), .data_i(db), .yumi_o(yumi_ob),
    .valid_o(valid_ob), .data_o(data_ob), .yumi_i(yb)
  );

  bsg_serial_in_parallel_out_frame #(.width_p(8), .els_p(1), .hi_to_lo_p(0)) dut_c (
    .clk_i(clk), .reset_i(rst), .v_i(vc), .data_i(dc), .yumi_o(yumi_oc),
    .valid_o(valid_oc), .data_o(data_oc), .yumi_i(yc)
  );

  // Drive one cycle of stimulus at the falling edge; yumi follows valid unless held.
  task automatic drive_a(input logic v, input logic [7:0] d);
    @(negedge clk);
    va = v; da = d; ya = a_hold ? 1'b0 : valid_oa;
    #1;
    if (ya && !valid_oa) begin
      errors++; $display("FAIL protocol_a: yumi_i=1 while valid_o=0");
    end
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d);
    @(negedge clk);
    vb = v; db = d; yb = valid_ob;
    #1;
    if (yb && !valid_ob) begin
      errors++; $display("FAIL protocol_b: yumi_i=1 while valid_o=0");
    end
  endtask

  function automatic logic [31:0] frame_of(input int base);
    logic [31:0] f;
    for (int j = 0; j < 4; j++) f[j*8 +: 8] = 8'(base + j);
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    va = 1'b1; da = 8'hFF; ya = 1'b0;
    vb = 1'b1; db = 8'hFF; yb = 1'b0;
    vc = 1'b1; dc = 8'hFF; yc = 1'b0;
    #12;
    checks++; if (yumi_oa !== 1'b0) begin errors++; $display("FAIL reset_yumi_a: got %b expected 0", yumi_oa); end
    checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", valid_oa); end
    checks++; if (data_oa !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h expected 0", data_oa); end
    checks++; if (yumi_ob !== 1'b0) begin errors++; $display("FAIL reset_yumi_b: got %b expected 0", yumi_ob); end
    checks++; if (valid_ob !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b expected 0", valid_ob); end
    checks++; if (yumi_oc !== 1'b0) begin errors++; $display("FAIL reset_yumi_c: got %b expected 0", yumi_oc); end
    checks++; if (valid_oc !== 1'b0) begin errors++; $display("FAIL reset_valid_c: got %b expected 0", valid_oc); end
    checks++; if (data_oc !== 8'h0) begin errors++; $display("FAIL reset_data_c: got %h expected 0", data_oc); end
    @(negedge clk);
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, w[i]);
      checks++; if (yumi_oa !== 1'b1) begin errors++; $display("FAIL single_yumi[%0d]: got %b expected 1", i, yumi_oa); end
      checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %b expected 0", i, valid_oa); end
    end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid_oa); end
    checks++; if (data_oa !== 32'h44332211) begin errors++; $display("FAIL single_data: got %h expected 44332211", data_oa); end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b expected 0", valid_oa); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      drive_a(1'b1, 8'(k + 1));
      checks++; if (yumi_oa !== 1'b1) begin errors++; $display("FAIL b2b_yumi[%0d]: got %b expected 1", k, yumi_oa); end
      checks++;
      if (valid_oa !== ((k > 0) && (k % 4 == 0))) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, valid_oa, (k > 0) && (k % 4 == 0));
      end
      if ((k > 0) && (k % 4 == 0)) begin
        checks++;
        if (data_oa !== frame_of(k - 3)) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, data_oa, frame_of(k - 3));
        end
      end
    end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b1) begin errors++; $display("FAIL b2b_last_valid: got %b expected 1", valid_oa); end
    checks++; if (data_oa !== 32'h0C0B0A09) begin errors++; $display("FAIL b2b_last_data: got %h expected 0c0b0a09", data_oa); end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", valid_oa); end
  endtask

  task automatic test_stall();
    a_hold = 1'b1;
    for (int i = 0; i < 4; i++) drive_a(1'b1, 8'hA1 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 8'hB1 + 8'(i));
      checks++; if (yumi_oa !== 1'b1) begin errors++; $display("FAIL stall_fill_yumi[%0d]: got %b expected 1", i, yumi_oa); end
      checks++; if (valid_oa !== 1'b1) begin errors++; $display("FAIL stall_fill_valid[%0d]: got %b expected 1", i, valid_oa); end
      checks++; if (data_oa !== 32'hA4A3A2A1) begin errors++; $display("FAIL stall_fill_data[%0d]: got %h expected a4a3a2a1", i, data_oa); end
    end
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b1, 8'hB4);
      checks++; if (yumi_oa !== 1'b0) begin errors++; $display("FAIL stall_last_yumi[%0d]: got %b expected 0", i, yumi_oa); end
      checks++; if (data_oa !== 32'hA4A3A2A1) begin errors++; $display("FAIL stall_hold_data[%0d]: got %h expected a4a3a2a1", i, data_oa); end
    end
    a_hold = 1'b0;
    drive_a(1'b1, 8'hB4);
    checks++; if (yumi_oa !== 1'b1) begin errors++; $display("FAIL stall_release_yumi: got %b expected 1", yumi_oa); end
    checks++; if (data_oa !== 32'hA4A3A2A1) begin errors++; $display("FAIL stall_release_data: got %h expected a4a3a2a1", data_oa); end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b1) begin errors++; $display("FAIL stall_b_valid: got %b expected 1", valid_oa); end
    checks++; if (data_oa !== 32'hB4B3B2B1) begin errors++; $display("FAIL stall_b_data: got %h expected b4b3b2b1", data_oa); end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", valid_oa); end
  endtask

  task automatic test_hi_to_lo();
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 8'h0A + 8'(i));
      checks++; if (yumi_ob !== 1'b1) begin errors++; $display("FAIL rev_yumi[%0d]: got %b expected 1", i, yumi_ob); end
    end
    drive_b(1'b0, 8'h00);
    checks++; if (valid_ob !== 1'b1) begin errors++; $display("FAIL rev_valid: got %b expected 1", valid_ob); end
    checks++; if (data_ob !== 32'h0A0B0C0D) begin errors++; $display("FAIL rev_data: got %h expected 0a0b0c0d", data_ob); end
    drive_b(1'b0, 8'h00);
    checks++; if (valid_ob !== 1'b0) begin errors++; $display("FAIL rev_drained: got %b expected 0", valid_ob); end
  endtask

  task automatic test_async_reset();
    a_hold = 1'b1;
    for (int i = 0; i < 4; i++) drive_a(1'b1, 8'h61 + 8'(i));
    drive_a(1'b1, 8'h51);
    drive_a(1'b1, 8'h52);
    drive_a(1'b1, 8'h53);
    checks++; if (valid_oa !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b expected 1", valid_oa); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", valid_oa); end
    checks++; if (data_oa !== 32'h0) begin errors++; $display("FAIL areset_data: got %h expected 0", data_oa); end
    checks++; if (yumi_oa !== 1'b0) begin errors++; $display("FAIL areset_yumi: got %b expected 0", yumi_oa); end
    @(negedge clk);
    va = 1'b0;
    rst = 1'b0;
    a_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 8'h71 + 8'(i));
      checks++; if (yumi_oa !== 1'b1) begin errors++; $display("FAIL areset_refill_yumi[%0d]: got %b expected 1", i, yumi_oa); end
    end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b1) begin errors++; $display("FAIL areset_clean_valid: got %b expected 1", valid_oa); end
    checks++; if (data_oa !== 32'h74737271) begin errors++; $display("FAIL areset_clean_data: got %h expected 74737271", data_oa); end
    drive_a(1'b0, 8'h00);
    checks++; if (valid_oa !== 1'b0) begin errors++; $display("FAIL areset_drained: got %b expected 0", valid_oa); end
  endtask

  task automatic test_els1_random();
    logic       full  = 1'b0;
    logic [7:0] mdata = 8'h00;
    logic       exp_y;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      vc = 1'($urandom_range(0, 1));
      dc = 8'($urandom);
      yc = valid_oc ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      exp_y = vc & (~full | yc);
      checks++;
      if (valid_oc !== full) begin
        errors++; $display("FAIL els1_valid[%0d]: got %b expected %b", n, valid_oc, full);
      end
      checks++;
      if (yumi_oc !== exp_y) begin
        errors++; $display("FAIL els1_yumi[%0d]: got %b expected %b", n, yumi_oc, exp_y);
      end
      if (full && yc) begin
        checks++;
        if (data_oc !== mdata) begin
          errors++; $display("FAIL els1_data[%0d]: got %h expected %h", n, data_oc, mdata);
        end
      end
      if (exp_y) begin
        full = 1'b1; mdata = dc;
      end else if (yc) begin
        full = 1'b0;
      end
    end
    @(negedge clk);
    vc = 1'b0; yc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_hi_to_lo();
    test_async_reset();
    test_els1_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
